// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run, debounced single-step, optional PC breakpoint.
// Optional feature: `define BREAKPOINT_EN enables breakpoint halt (HALT state, halted output).
module cpu_clk_ctrl #(
  parameter int unsigned DIVISOR         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_sw,
  input  logic                  step_btn,
  input  logic [1:0]            div_sel,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic                  bp_valid,
  output logic                  clk_en,
  output logic [1:0]            state,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  cycle_cnt
);

  localparam int DW = $clog2(DIVISOR) + 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_BASE = DW'(DIVISOR);
  localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic run_meta_q, run_meta_d;
  logic run_s_q, run_s_d;
  logic step_meta_q, step_meta_d;
  logic step_s_q, step_s_d;

  logic          dbn_level_q, dbn_level_d;
  logic [BW-1:0] dbn_cnt_q, dbn_cnt_d;
  logic          step_evt_q, step_evt_d;

  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] per;
  logic          tick;
  logic          bp_hit;

  logic [1:0]           state_q, state_d;
  logic                 clk_en_q, clk_en_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    run_meta_d  = run_sw;
    run_s_d     = run_meta_q;
    step_meta_d = step_btn;
    step_s_d    = step_meta_q;
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    dbn_level_d = dbn_level_q;
    dbn_cnt_d   = '0;
    if (step_s_q != dbn_level_q) begin
      if (dbn_cnt_q == DB_LAST) begin
        dbn_level_d = step_s_q;
      end else begin
        dbn_cnt_d = dbn_cnt_q + BW'(1);
      end
    end
    step_evt_d = dbn_level_d & ~dbn_level_q;
  end

  always_comb begin
    per  = DIV_BASE >> {div_sel, 1'b0};
    tick = (per <= DW'(1)) ||
           (div_q >= (per - DW'(1)));
  end

`ifdef BREAKPOINT_EN
  always_comb begin
    bp_hit = bp_valid && (pc == bp_addr);
  end
`else
  logic unused_bp;
  always_comb begin
    unused_bp = ^{pc, bp_addr, bp_valid};
    bp_hit    = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    clk_en_d = 1'b0;
    div_d    = '0;
    unique case (1'b1)
      (state_q == S_RUN): begin
        if (!run_s_q) begin
          state_d = S_STEP;
        end else if (tick && bp_hit) begin
          state_d = S_HALT;
        end else if (tick) begin
          clk_en_d = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      (state_q == S_STEP): begin
        if (step_evt_q) begin
          state_d = S_FIRE;
        end else if (run_s_q) begin
          state_d = S_RUN;
        end
      end
      (state_q == S_FIRE): begin
        clk_en_d = 1'b1;
        state_d  = run_s_q ? S_RUN : S_STEP;
      end
      (state_q == S_HALT): begin
`ifdef BREAKPOINT_EN
        if (step_evt_q) begin
          state_d = S_FIRE;
        end
`else
        state_d = S_STEP;
`endif
      end
      default: begin
        state_d = S_STEP;
      end
    endcase
    cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(clk_en_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      dbn_level_q <= 1'b0;
      dbn_cnt_q   <= '0;
      step_evt_q  <= 1'b0;
      div_q       <= '0;
      state_q     <= S_STEP;
      clk_en_q    <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      run_meta_q  <= run_meta_d;
      run_s_q     <= run_s_d;
      step_meta_q <= step_meta_d;
      step_s_q    <= step_s_d;
      dbn_level_q <= dbn_level_d;
      dbn_cnt_q   <= dbn_cnt_d;
      step_evt_q  <= step_evt_d;
      div_q       <= div_d;
      state_q     <= state_d;
      clk_en_q    <= clk_en_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

`ifdef BREAKPOINT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: pulse scoreboard plus div_sel vector table.
// Breakpoint sequence runs only when BREAKPOINT_EN is defined.
module tb_cpu_clk_ctrl;

  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic [1:0]    div_sel = 2'd0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_valid = 1'b0;
  logic          clk_en;
  logic [1:0]    state;
  logic          halted;
  logic [CW-1:0] cycle_cnt;

  cpu_clk_ctrl #(
    .DIVISOR(8),
    .DEBOUNCE_CYCLES(4),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .div_sel(div_sel),
    .pc(pc),
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .clk_en(clk_en),
    .state(state),
    .halted(halted),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            at;
    logic [CW-1:0] cnt;
  } pulse_t;

  typedef struct {
    logic [1:0] div;
    int         per;
  } vec_t;

  pulse_t        sb_q[$];
  vec_t          vecs[5];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_pulse(input int at);
    pulse_t p;
    exp_cnt = exp_cnt + 1'b1;
    p.at  = at;
    p.cnt = exp_cnt;
    sb_q.push_back(p);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    if (c > cyc) adv(c - cyc);
  endtask

  // Pulse monitor: each clk_en must match the head of the scoreboard
  always @(posedge clk) begin
    cyc++;
    #2;
    while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      chk("pulse_missed_at", cyc, sb_q[0].at);
      void'(sb_q.pop_front());
    end
    if (rst_n && clk_en) begin
      if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
        chk("pulse_cycle_cnt", cycle_cnt, sb_q[0].cnt);
        void'(sb_q.pop_front());
      end else begin
        chk("unexpected_pulse_cyc", cyc,
            (sb_q.size() > 0) ? sb_q[0].at : 0);
      end
    end
  end

  initial begin
    int r, c, s;
    vecs[0] = '{div: 2'd0, per: 8};
    vecs[1] = '{div: 2'd1, per: 2};
    vecs[2] = '{div: 2'd3, per: 1};
    vecs[3] = '{div: 2'd2, per: 1};
    vecs[4] = '{div: 2'd0, per: 8};

    rst_n  = 1'b0;
    run_sw = 1'b1;
    adv(3);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_state", state, 1);
    chk("rst_halted", halted, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);

    // free-run start-up
    r = cyc;
    rst_n = 1'b1;
    expect_pulse(r + 11);
    expect_pulse(r + 19);
    expect_pulse(r + 27);
    adv(2);
    chk("state_during_sync", state, 1);
    adv(1);
    chk("state_run", state, 0);
    wait_until(r + 27);
    chk("cnt_after_three", cycle_cnt, 3);

    // rate table, each entry starts on a pulse edge
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      div_sel = vecs[i].div;
      for (int k = 1; k <= 3; k++) begin
        expect_pulse(c + k * vecs[i].per);
      end
      wait_until(c + 3 * vecs[i].per);
      chk("table_cnt", cycle_cnt, exp_cnt);
    end

    // div_sel 0->1 with divider at 5
    c = cyc;
    wait_until(c + 5);
    div_sel = 2'd1;
    expect_pulse(c + 6);
    expect_pulse(c + 8);
    expect_pulse(c + 10);
    wait_until(c + 10);
    div_sel = 2'd0;
    expect_pulse(c + 18);
    wait_until(c + 18);
    chk("midcount_cnt", cycle_cnt, exp_cnt);

    // run_sw drop with divider at 6
    c = cyc;
    wait_until(c + 4);
    run_sw = 1'b0;
    wait_until(c + 7);
    chk("drop_state_step", state, 1);
    chk("drop_no_pulse", clk_en, 0);
    wait_until(c + 10);
    run_sw = 1'b1;
    expect_pulse(c + 21);
    wait_until(c + 13);
    chk("rerun_state", state, 0);
    wait_until(c + 21);

    // single-step: glitches then one long press
    c = cyc;
    run_sw = 1'b0;
    wait_until(c + 3);
    chk("step_mode_state", state, 1);
    for (int l = 1; l <= 3; l++) begin
      step_btn = 1'b1;
      adv(l);
      step_btn = 1'b0;
      adv(6);
      chk("glitch_state", state, 1);
      chk("glitch_cnt", cycle_cnt, exp_cnt);
    end
    s = cyc;
    step_btn = 1'b1;
    expect_pulse(s + 8);
    wait_until(s + 7);
    chk("press_fire_state", state, 2);
    adv(1);
    chk("press_back_step", state, 1);
    chk("press_halted", halted, 0);
    wait_until(s + 20);
    step_btn = 1'b0;
    adv(10);
    chk("press_cnt", cycle_cnt, exp_cnt);

    // reset in the middle of a pulse
    c = cyc;
    run_sw = 1'b1;
    expect_pulse(c + 11);
    wait_until(c + 11);
    chk("pulse_before_reset", clk_en, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_en", clk_en, 0);
    chk("async_rst_cnt", cycle_cnt, 0);
    chk("async_rst_state", state, 1);
    exp_cnt = '0;
    adv(2);
    r = cyc;
    rst_n = 1'b1;
    expect_pulse(r + 11);
    wait_until(r + 11);
    chk("resume_state", state, 0);

`ifdef BREAKPOINT_EN
    c = cyc;
    bp_valid = 1'b1;
    bp_addr  = 6'd5;
    pc       = 6'd5;
    wait_until(c + 8);
    chk("bp_state_halt", state, 3);
    chk("bp_halted", halted, 1);
    chk("bp_no_pulse", clk_en, 0);
    run_sw = 1'b0;
    adv(5);
    chk("bp_ignore_run0", state, 3);
    run_sw = 1'b1;
    adv(5);
    chk("bp_ignore_run1", state, 3);
    s = cyc;
    step_btn = 1'b1;
    expect_pulse(s + 8);
    wait_until(s + 7);
    chk("bp_fire_state", state, 2);
    chk("bp_fire_halted", halted, 0);
    adv(1);
    chk("bp_resume_run", state, 0);
    run_sw   = 1'b0;
    pc       = 6'd6;
    step_btn = 1'b0;
    adv(10);
    chk("bp_final_state", state, 1);
`endif

    adv(2);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
